bram_port_arbiter: RTL and testbench

- Shares one single-port block RAM (2-cycle registered read latency, reset-busy flag) between two requesters, A and B.
- Each requester issues read/write command beats on a valid/ready channel. Read data returns on a per-requester response strobe after a fixed latency.
- Round-robin arbitration with a bounded burst length. Lets a built-in memory test engine and a processor-side port use the same RAM.

---
 rtl/bram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port block RAM.
// Read responses are routed back to their issuer through a fixed-latency tag pipeline.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  a_cmd_tvalid,
  output logic                  a_cmd_tready,
  input  logic                  a_cmd_we,
  input  logic [ADDR_WIDTH-1:0] a_cmd_addr,
  input  logic [DATA_WIDTH-1:0] a_cmd_wdata,
  output logic                  a_rsp_tvalid,
  output logic [DATA_WIDTH-1:0] a_rsp_tdata,

  input  logic                  b_cmd_tvalid,
  output logic                  b_cmd_tready,
  input  logic                  b_cmd_we,
  input  logic [ADDR_WIDTH-1:0] b_cmd_addr,
  input  logic [DATA_WIDTH-1:0] b_cmd_wdata,
  output logic                  b_rsp_tvalid,
  output logic [DATA_WIDTH-1:0] b_rsp_tdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rst_busy,

  output logic [1:0]            owner
);

  typedef enum logic [1:0] {
    S_RESET_BUSY,
    S_IDLE,
    S_OWN_A,
    S_OWN_B
  } state_t;

  localparam logic [1:0] ID_NONE = 2'b00;
  localparam logic [1:0] ID_A    = 2'b01;
  localparam logic [1:0] ID_B    = 2'b10;

  localparam int              CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  state_t           state;
  logic [1:0]       last_owner;
  logic [CNT_W-1:0] burst_cnt;
  logic [1:0]       sel;
  logic             sel_we;
  logic [1:0]       tag_q [READ_LATENCY];

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the block can leave it holding a stale value (a latch).
  // A RAM still in its reset sequence is never handed a beat, even before the
  // state register has caught up with mem_rst_busy.
  always_comb begin
    sel = ID_NONE;
    if (!mem_rst_busy) begin
      unique case (state)
        S_IDLE: begin
          if (a_cmd_tvalid && b_cmd_tvalid) sel = (last_owner == ID_A) ? ID_B : ID_A;
          else if (a_cmd_tvalid)            sel = ID_A;
          else if (b_cmd_tvalid)            sel = ID_B;
        end
        S_OWN_A: begin
          if (a_cmd_tvalid && (!b_cmd_tvalid || burst_cnt < BURST_MAX)) sel = ID_A;
          else if (b_cmd_tvalid)                                        sel = ID_B;
        end
        S_OWN_B: begin
          if (b_cmd_tvalid && (!a_cmd_tvalid || burst_cnt < BURST_MAX)) sel = ID_B;
          else if (a_cmd_tvalid)                                        sel = ID_A;
        end
        default: sel = ID_NONE;
      endcase
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (sel)
      ID_A: begin
        sel_we    = a_cmd_we;
        mem_addr  = a_cmd_addr;
        mem_wdata = a_cmd_wdata;
      end
      ID_B: begin
        sel_we    = b_cmd_we;
        mem_addr  = b_cmd_addr;
        mem_wdata = b_cmd_wdata;
      end
      default: ;
    endcase
  end

  assign a_cmd_tready = (sel == ID_A);
  assign b_cmd_tready = (sel == ID_B);
  assign mem_en       = (sel != ID_NONE);
  assign mem_we       = sel_we;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_RESET_BUSY;
      owner      <= ID_NONE;
      last_owner <= ID_B;
      burst_cnt  <= '0;
    end else if (state == S_RESET_BUSY) begin
      if (!mem_rst_busy) state <= S_IDLE;
    end else if (mem_rst_busy) begin
      state     <= S_RESET_BUSY;
      owner     <= ID_NONE;
      burst_cnt <= '0;
    end else if (sel != ID_NONE) begin
      state      <= (sel == ID_A) ? S_OWN_A : S_OWN_B;
      owner      <= sel;
      last_owner <= sel;
      if (sel != owner)                burst_cnt <= CNT_W'(1);
      else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
    end else begin
      state     <= S_IDLE;
      owner     <= ID_NONE;
      burst_cnt <= '0;
    end
  end

  // NOTE: the tag pipeline is a handful of flops, so it is reset outright;
  // that is what discards in-flight reads when resetn is asserted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= ID_NONE;
    end else begin
      tag_q[0] <= (mem_en && !sel_we) ? sel : ID_NONE;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign a_rsp_tvalid = (tag_q[READ_LATENCY-1] == ID_A);
  assign b_rsp_tvalid = (tag_q[READ_LATENCY-1] == ID_B);
  assign a_rsp_tdata  = a_rsp_tvalid ? mem_rdata : '0;
  assign b_rsp_tdata  = b_rsp_tvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural 2-cycle block RAM.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_bram_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        a_cmd_tvalid, a_cmd_tready, a_cmd_we;
  logic [9:0]  a_cmd_addr;
  logic [31:0] a_cmd_wdata;
  logic        a_rsp_tvalid;
  logic [31:0] a_rsp_tdata;
  logic        b_cmd_tvalid, b_cmd_tready, b_cmd_we;
  logic [9:0]  b_cmd_addr;
  logic [31:0] b_cmd_wdata;
  logic        b_rsp_tvalid;
  logic [31:0] b_rsp_tdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rst_busy;
  logic [1:0]  owner;

  int passed = 0;
  int total  = 0;

  bram_port_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .a_cmd_tvalid (a_cmd_tvalid),
    .a_cmd_tready (a_cmd_tready),
    .a_cmd_we     (a_cmd_we),
    .a_cmd_addr   (a_cmd_addr),
    .a_cmd_wdata  (a_cmd_wdata),
    .a_rsp_tvalid (a_rsp_tvalid),
    .a_rsp_tdata  (a_rsp_tdata),
    .b_cmd_tvalid (b_cmd_tvalid),
    .b_cmd_tready (b_cmd_tready),
    .b_cmd_we     (b_cmd_we),
    .b_cmd_addr   (b_cmd_addr),
    .b_cmd_wdata  (b_cmd_wdata),
    .b_rsp_tvalid (b_rsp_tvalid),
    .b_rsp_tdata  (b_rsp_tdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rst_busy (mem_rst_busy),
    .owner        (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM model: write lands at the edge, read data is registered twice.
  logic [31:0] ram [1024];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        rd_q          <= ram[mem_addr];
    end
    mem_rdata <= rd_q;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_a(input logic v, input logic we, input logic [9:0] addr, input logic [31:0] data);
    a_cmd_tvalid = v;
    a_cmd_we     = we;
    a_cmd_addr   = addr;
    a_cmd_wdata  = data;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [9:0] addr, input logic [31:0] data);
    b_cmd_tvalid = v;
    b_cmd_we     = we;
    b_cmd_addr   = addr;
    b_cmd_wdata  = data;
  endtask

  initial begin
    logic       exp_a;
    logic [1:0] prev_grant;

    // Reset with the RAM still busy and A already requesting.
    resetn       = 1'b0;
    mem_rst_busy = 1'b1;
    set_a(1'b1, 1'b1, 10'd0, 32'h11);
    set_b(1'b0, 1'b0, 10'd0, 32'h0);
    @(negedge clk); #1;
    check("rst_owner",    64'(owner), 64'd0);
    check("rst_a_tready", 64'(a_cmd_tready), 64'd0);
    check("rst_mem_en",   64'(mem_en), 64'd0);
    check("rst_a_rsp",    64'(a_rsp_tvalid), 64'd0);

    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("busy_a_tready", 64'(a_cmd_tready), 64'd0);
      check("busy_mem_en",   64'(mem_en), 64'd0);
      @(negedge clk);
    end
    mem_rst_busy = 1'b0;
    #1;
    check("busy_fall_a_tready", 64'(a_cmd_tready), 64'd0);

    // A writes 0x11..0x44 to addresses 0..3; first grant right after busy falls.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_a(1'b1, 1'b1, 10'(i), 32'((i + 1) * 'h11));
      #1;
      check("wr_a_tready", 64'(a_cmd_tready), 64'd1);
      check("wr_mem_we",   64'(mem_we), 64'd1);
      check("wr_mem_addr", 64'(mem_addr), 64'(i));
      check("wr_mem_wdata", 64'(mem_wdata), 64'((i + 1) * 'h11));
      check("wr_owner",    64'(owner), (i == 0) ? 64'd0 : 64'd1);
    end

    // Back-to-back reads; responses arrive two cycles later in order.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 4) set_a(1'b1, 1'b0, 10'(i), 32'h0);
      else       set_a(1'b0, 1'b0, 10'd0, 32'h0);
      #1;
      check("rd_a_rsp_valid", 64'(a_rsp_tvalid), (i >= 2 && i <= 5) ? 64'd1 : 64'd0);
      check("rd_a_rsp_data",  64'(a_rsp_tdata), (i >= 2 && i <= 5) ? 64'((i - 1) * 'h11) : 64'd0);
      check("rd_b_rsp_valid", 64'(b_rsp_tvalid), 64'd0);
      check("rd_mem_en",      64'(mem_en), (i < 4) ? 64'd1 : 64'd0);
    end

    // Preload 5/6, write-then-read 7, then A reads 5 and B reads 6 back to back.
    @(negedge clk); set_a(1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    @(negedge clk); set_a(1'b1, 1'b1, 10'd6, 32'hCAFEF00D);
    @(negedge clk); set_a(1'b1, 1'b1, 10'd7, 32'h77);
    @(negedge clk); set_a(1'b1, 1'b0, 10'd7, 32'h0);
    #1 check("raw_a_tready", 64'(a_cmd_tready), 64'd1);
    @(negedge clk); set_a(1'b1, 1'b0, 10'd5, 32'h0);
    #1 check("rd5_a_tready", 64'(a_cmd_tready), 64'd1);
    @(negedge clk);
    set_a(1'b0, 1'b0, 10'd0, 32'h0);
    set_b(1'b1, 1'b0, 10'd6, 32'h0);
    #1;
    check("rd6_b_tready", 64'(b_cmd_tready), 64'd1);
    check("rd6_a_tready", 64'(a_cmd_tready), 64'd0);
    check("rd6_mem_addr", 64'(mem_addr), 64'd6);
    check("raw_rsp_valid", 64'(a_rsp_tvalid), 64'd1);
    check("raw_rsp_data",  64'(a_rsp_tdata), 64'h77);
    @(negedge clk);
    set_b(1'b0, 1'b0, 10'd0, 32'h0);
    #1;
    check("rd5_a_rsp_valid", 64'(a_rsp_tvalid), 64'd1);
    check("rd5_a_rsp_data",  64'(a_rsp_tdata), 64'hDEADBEEF);
    check("rd5_b_rsp_valid", 64'(b_rsp_tvalid), 64'd0);
    @(negedge clk); #1;
    check("rd6_b_rsp_valid", 64'(b_rsp_tvalid), 64'd1);
    check("rd6_b_rsp_data",  64'(b_rsp_tdata), 64'hCAFEF00D);
    check("rd6_a_rsp_valid", 64'(a_rsp_tvalid), 64'd0);
    check("rd6_a_rsp_data",  64'(a_rsp_tdata), 64'd0);

    // Fresh reset, both requesters write continuously: 16 A, 16 B, then A again.
    @(negedge clk);
    resetn = 1'b0;
    #1 check("rst2_owner", 64'(owner), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    set_a(1'b1, 1'b1, 10'd100, 32'hA0);
    set_b(1'b1, 1'b1, 10'd200, 32'hB0);
    #1 check("rst2_a_tready", 64'(a_cmd_tready), 64'd0);
    prev_grant = 2'b00;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk); #1;
      exp_a = (k < 16) || (k >= 32);
      check("rr_a_tready",  64'(a_cmd_tready), 64'(exp_a));
      check("rr_b_tready",  64'(b_cmd_tready), 64'(!exp_a));
      check("rr_mem_addr",  64'(mem_addr), exp_a ? 64'd100 : 64'd200);
      check("rr_owner",     64'(owner), 64'(prev_grant));
      prev_grant = exp_a ? 2'b01 : 2'b10;
    end

    // Idle cycle, then A streams 40 beats alone; B then wins immediately.
    @(negedge clk);
    set_a(1'b0, 1'b0, 10'd0, 32'h0);
    set_b(1'b0, 1'b0, 10'd0, 32'h0);
    #1 check("idle_mem_en", 64'(mem_en), 64'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      set_a(1'b1, 1'b1, 10'(300 + k), 32'(k));
      #1 check("stream_a_tready", 64'(a_cmd_tready), 64'd1);
    end
    @(negedge clk);
    set_b(1'b1, 1'b1, 10'd400, 32'hB1);
    #1;
    check("sat_b_tready", 64'(b_cmd_tready), 64'd1);
    check("sat_a_tready", 64'(a_cmd_tready), 64'd0);
    check("sat_owner",    64'(owner), 64'd1);
    @(negedge clk); #1;
    check("sat2_b_tready", 64'(b_cmd_tready), 64'd1);
    check("sat2_owner",    64'(owner), 64'd2);

    // Read accepted, then resetn pulsed: its response must never appear.
    @(negedge clk);
    set_b(1'b0, 1'b0, 10'd0, 32'h0);
    set_a(1'b1, 1'b0, 10'd5, 32'h0);
    #1 check("pulse_rd_a_tready", 64'(a_cmd_tready), 64'd1);
    @(negedge clk);
    set_a(1'b0, 1'b0, 10'd0, 32'h0);
    resetn = 1'b0;
    #1;
    check("pulse_owner",     64'(owner), 64'd0);
    check("pulse_a_rsp_0",   64'(a_rsp_tvalid), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("pulse_a_rsp_1",   64'(a_rsp_tvalid), 64'd0);
    check("pulse_a_rsp_data", 64'(a_rsp_tdata), 64'd0);
    @(negedge clk); #1;
    check("pulse_a_rsp_2",   64'(a_rsp_tvalid), 64'd0);
    check("pulse_b_rsp_2",   64'(b_rsp_tvalid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
